// File: rtl/bsg_downstream_link_rx.sv
// Downstream link receiver: pairs IO half-words into buffered words, gathers CORE_WORDS of them per core beat, returns toggle-coded credit.
// Optional build macro DOWNSTREAM_OVERFLOW_DETECT_EN enables the sticky overflow_err flag and a drop assertion.
module bsg_downstream_link_rx #(
  parameter int IO_WIDTH       = 8,
  parameter int LG_DEPTH       = 3,
  parameter int CORE_WORDS     = 2,
  parameter int LG_TOKEN_DECIM = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               io_valid_in,
  input  logic [IO_WIDTH-1:0]                io_data_in,
  output logic                               io_token_out,
  output logic [CORE_WORDS*2*IO_WIDTH-1:0]   core_data_out,
  output logic                               core_valid_out,
  input  logic                               core_ready,
  output logic [LG_DEPTH:0]                  fifo_count,
  output logic                               overflow_err
);

  localparam int W          = 2 * IO_WIDTH;
  localparam int DEPTH      = 1 << LG_DEPTH;
  localparam int CORE_WIDTH = CORE_WORDS * W;
  localparam int GW         = $clog2(CORE_WORDS + 1);

  logic                  half_valid;
  logic [IO_WIDTH-1:0]   io_data;
  logic [LG_DEPTH:0]     wptr, rptr;
  logic [W-1:0]          mem [DEPTH];
  logic [W-1:0]          rdata;
  logic [GW-1:0]         gcnt, gcnt_inc;
  logic [CORE_WIDTH-1:0] gather, gather_n;
  logic                  empty, full, push, push_ok, drop, pop;
  logic                  complete, slot_free, load;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[LG_DEPTH] != rptr[LG_DEPTH]) &&
                   (wptr[LG_DEPTH-1:0] == rptr[LG_DEPTH-1:0]);
  assign push    = io_valid_in && half_valid;
  assign push_ok = push && !full;
  assign drop    = push && full;
  assign pop     = !empty && (gcnt != GW'(CORE_WORDS));
  assign rdata   = mem[rptr[LG_DEPTH-1:0]];

  assign gcnt_inc   = gcnt + GW'(pop);
  assign complete   = (gcnt_inc == GW'(CORE_WORDS));
  assign slot_free  = !core_valid_out || core_ready;
  assign load       = complete && slot_free;
  assign fifo_count = wptr - rptr;

  // The popped word lands in slot gcnt; a beat load takes this merged view.
  always_comb begin
    gather_n = gather;
    for (int i = 0; i < CORE_WORDS; i++) begin
      if (pop && (gcnt == GW'(i))) gather_n[i*W +: W] = rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[LG_DEPTH-1:0]] <= {io_data_in, io_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_valid     <= 1'b0;
      io_data        <= '0;
      wptr           <= '0;
      rptr           <= '0;
      gcnt           <= '0;
      gather         <= '0;
      core_data_out  <= '0;
      core_valid_out <= 1'b0;
    end else begin
      if (io_valid_in) begin
        if (!half_valid) begin
          io_data    <= io_data_in;
          half_valid <= 1'b1;
        end else begin
          half_valid <= 1'b0;
        end
      end
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      gcnt   <= load ? '0 : gcnt_inc;
      gather <= gather_n;
      if (load) begin
        core_data_out  <= gather_n;
        core_valid_out <= 1'b1;
      end else if (core_ready) begin
        core_valid_out <= 1'b0;
      end
    end
  end

  generate
    if (LG_TOKEN_DECIM == 0) begin : g_tok_every
      always_ff @(posedge clk) begin
        if (rst)      io_token_out <= 1'b0;
        else if (pop) io_token_out <= ~io_token_out;
      end
    end else begin : g_tok_decim
      logic [LG_TOKEN_DECIM-1:0] pcnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          pcnt         <= '0;
          io_token_out <= 1'b0;
        end else if (pop) begin
          pcnt <= pcnt + 1'b1;
          if (&pcnt) io_token_out <= ~io_token_out;
        end
      end
    end
  endgenerate

`ifdef DOWNSTREAM_OVERFLOW_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst)       overflow_err <= 1'b0;
    else if (drop) overflow_err <= 1'b1;
  end

  always @(posedge clk) begin
    assert (rst || !drop) else $error("downstream link rx: word dropped, buffer full");
  end
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_downstream_link_rx.sv
// Scoreboard bench: queue-based reference model feeds expected beats; a negedge monitor compares DUT outputs.
module tb_bsg_downstream_link_rx;
  localparam int IO_WIDTH = 8;
  localparam int LG_DEPTH = 3;
  localparam int CW       = 2;
  localparam int LGT      = 2;
  localparam int W        = 2 * IO_WIDTH;
  localparam int DEPTH    = 1 << LG_DEPTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 io_valid_in;
  logic [IO_WIDTH-1:0]  io_data_in;
  logic                 io_token_out;
  logic [CW*W-1:0]      core_data_out;
  logic                 core_valid_out;
  logic                 core_ready;
  logic [LG_DEPTH:0]    fifo_count;
  logic                 overflow_err;

  bsg_downstream_link_rx #(
    .IO_WIDTH(IO_WIDTH), .LG_DEPTH(LG_DEPTH), .CORE_WORDS(CW), .LG_TOKEN_DECIM(LGT)
  ) dut (
    .clk(clk), .rst(rst), .io_valid_in(io_valid_in), .io_data_in(io_data_in),
    .io_token_out(io_token_out), .core_data_out(core_data_out),
    .core_valid_out(core_valid_out), .core_ready(core_ready),
    .fifo_count(fifo_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0]    buf_q[$];
  logic [W-1:0]    gath_q[$];
  logic [CW*W-1:0] exp_q[$];
  logic            m_half_v;
  logic [IO_WIDTH-1:0] m_half_d;
  logic            m_valid;
  logic [CW*W-1:0] m_data;
  logic            m_tok;
  logic            m_ovf;
  int              m_pcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit full, empty, accept, slot_free;
    logic [CW*W-1:0] beat;
    if (rst) begin
      buf_q.delete(); gath_q.delete(); exp_q.delete();
      m_half_v = 0; m_half_d = '0; m_valid = 0; m_data = '0;
      m_tok = 0; m_ovf = 0; m_pcnt = 0;
      return;
    end
    full      = (buf_q.size() == DEPTH);
    empty     = (buf_q.size() == 0);
    accept    = m_valid && core_ready;
    slot_free = !m_valid || core_ready;
    if (!empty && gath_q.size() < CW) begin
      gath_q.push_back(buf_q.pop_front());
      m_pcnt = (m_pcnt + 1) % (1 << LGT);
      if (m_pcnt == 0) m_tok = ~m_tok;
    end
    if (io_valid_in) begin
      if (m_half_v) begin
        m_half_v = 0;
        if (!full) buf_q.push_back({io_data_in, m_half_d});
        else m_ovf = 1;
      end else begin
        m_half_v = 1;
        m_half_d = io_data_in;
      end
    end
    if (gath_q.size() == CW && slot_free) begin
      for (int i = 0; i < CW; i++) beat[i*W +: W] = gath_q[i];
      gath_q.delete();
      m_valid = 1;
      m_data  = beat;
      exp_q.push_back(beat);
    end else if (accept) begin
      m_valid = 0;
    end
  endtask

  task automatic cycle(input logic v, input logic [IO_WIDTH-1:0] d);
    io_valid_in = v;
    io_data_in  = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!core_valid_out && n < budget) begin
      cycle(1'b0, '0);
      n++;
    end
    checks++;
    if (!core_valid_out) begin
      errors++;
      $display("FAIL %s timeout: core_valid_out=0 required 1 after %0d cycles", name, budget);
    end
  endtask

  // Monitor: compares DUT against model every cycle; pops scoreboard on accept.
  always @(negedge clk) begin
    if (!$isunknown(rst) && m_valid !== 1'bx) begin
      check("core_valid_out", 64'(core_valid_out), 64'(m_valid));
      check("fifo_count", 64'(fifo_count), 64'(buf_q.size()));
      check("io_token_out", 64'(io_token_out), 64'(m_tok));
`ifdef DOWNSTREAM_OVERFLOW_DETECT_EN
      check("overflow_err", 64'(overflow_err), 64'(m_ovf));
`else
      check("overflow_err", 64'(overflow_err), 64'(0));
`endif
      if (core_valid_out && core_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_order actual=%0h expected=none (scoreboard empty)", core_data_out);
        end else begin
          check("beat_data", 64'(core_data_out), 64'(exp_q.pop_front()));
        end
      end else if (core_valid_out && m_valid) begin
        check("beat_hold", 64'(core_data_out), 64'(m_data));
      end
    end
  end

  initial begin
    m_valid = 1'bx;
    rst = 1; io_valid_in = 0; io_data_in = '0; core_ready = 0;
    repeat (3) cycle(1'b0, '0);
    check("reset_valid", 64'(core_valid_out), 64'(0));
    check("reset_data", 64'(core_data_out), 64'(0));
    check("reset_count", 64'(fifo_count), 64'(0));
    check("reset_token", 64'(io_token_out), 64'(0));
    rst = 0;

    // Pairing
    cycle(1, 8'h34); cycle(1, 8'h12); cycle(1, 8'h78); cycle(1, 8'h56);
    wait_valid(10, "pairing");
    check("pairing_beat", 64'(core_data_out), 64'h56781234);
    repeat (3) cycle(0, '0);
    core_ready = 1;
    cycle(0, '0);
    core_ready = 0;
    cycle(0, '0);

    // Backpressure into overflow: 14 words offered, output+gather+buffer hold 12
    for (int i = 0; i < 28; i++) cycle(1, 8'($urandom));
    repeat (4) cycle(0, '0);
    check("overflow_count", 64'(fifo_count), 64'(DEPTH));
    core_ready = 1;
    repeat (30) cycle(0, '0);
    check("drain_count", 64'(fifo_count), 64'(0));

    // Continuous traffic with core ready: pointers wrap
    for (int i = 0; i < 80; i++) begin
      cycle(1, 8'($urandom));
      checks++;
      if (fifo_count > 1) begin
        errors++;
        $display("FAIL stream_occupancy actual=%0d required<=1", fifo_count);
      end
    end
    repeat (8) cycle(0, '0);

    // Random traffic and backpressure
    for (int i = 0; i < 600; i++) begin
      core_ready = ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 2) != 0), 8'($urandom));
    end
    core_ready = 1;
    repeat (30) cycle(0, '0);

    // Reset mid-operation
    core_ready = 0;
    for (int i = 0; i < 7; i++) cycle(1, 8'($urandom));
    rst = 1;
    cycle(0, '0);
    rst = 0;
    check("midrst_valid", 64'(core_valid_out), 64'(0));
    check("midrst_count", 64'(fifo_count), 64'(0));
    check("midrst_data", 64'(core_data_out), 64'(0));
    check("midrst_token", 64'(io_token_out), 64'(0));
    cycle(1, 8'hBB); cycle(1, 8'hAA); cycle(1, 8'hDD); cycle(1, 8'hCC);
    wait_valid(10, "post_reset");
    check("post_reset_beat", 64'(core_data_out), 64'hCCDDAABB);
    core_ready = 1;
    repeat (4) cycle(0, '0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
